// File: rtl/seg_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with per-frame snapshot and blink.
// Optional build macro SCAN_DP_EN lights the dp on digit 1 as a mm.ss separator.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 72000,
  parameter int unsigned BLINK_DIV   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min10,
  input  logic [3:0] min1,
  input  logic [3:0] sec10,
  input  logic [3:0] sec1,
  input  logic [3:0] blink_mask,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       frame_start
);

  localparam logic [31:0] RLAST = 32'(REFRESH_DIV - 1);
  localparam logic [31:0] BLAST = 32'(BLINK_DIV - 1);

  logic [31:0]      refresh_cnt_q, refresh_cnt_d;
  logic [31:0]      blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             frame_start_q, frame_start_d;

  logic             tick;
  logic             blink_wrap;
  logic             frame_wrap;
  logic [1:0]       idx_nxt;
  logic [3:0]       digit;
  logic             blank;
  logic [7:0]       seg_nxt;

  // BCD to active-low g..a; anything above 9 is blank
  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next-state: timing counters, snapshot, and the digit loaded on each tick
  always_comb begin
    tick          = (refresh_cnt_q == RLAST);
    refresh_cnt_d = tick ? '0 : refresh_cnt_q + 32'd1;
    blink_wrap    = (blink_cnt_q == BLAST);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 32'd1;
    blink_on_d    = blink_on_q ^ blink_wrap;

    idx_nxt    = idx_q + 2'd1;
    frame_wrap = tick && (idx_q == 2'd3);
    snap_d     = frame_wrap ? {min10, min1, sec10, sec1} : snap_q;

    // digit 0 comes straight from the input on the capture tick
    digit   = (idx_nxt == 2'd0) ? min10 : snap_q[~idx_nxt];
    blank   = ~blink_on_q & blink_mask[~idx_nxt];
    seg_nxt = blank ? 8'hFF : {1'b1, dec7(digit)};
`ifdef SCAN_DP_EN
    if (idx_nxt == 2'd1) seg_nxt[7] = 1'b0;
`else
    seg_nxt[7] = 1'b1;
`endif

    idx_d         = idx_q;
    an_d          = an_q;
    seg_d         = seg_q;
    frame_start_d = frame_wrap;
    if (tick) begin
      idx_d = idx_nxt;
      an_d  = ~(4'b1000 >> idx_nxt);
      seg_d = seg_nxt;
    end
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt_q <= '0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      idx_q         <= 2'd3;
      snap_q        <= '0;
      an_q          <= 4'b1111;
      seg_q         <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-count reference model plus scenario tasks.
// Define SCAN_DP_EN for both bench and RTL to exercise the dp build.
module tb_seg_scan_driver;

  localparam int R = 4;
  localparam int B = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] min10 = '0;
  logic [3:0] min1 = '0;
  logic [3:0] sec10 = '0;
  logic [3:0] sec1 = '0;
  logic [3:0] blink_mask = '0;
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame_start;

  int vectors = 0;
  int errors  = 0;

  seg_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .blink_mask(blink_mask),
    .an(an), .seg(seg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: everything derives from n = posedges seen since reset
  logic [7:0] tab [16];
  logic [3:0] fr [4];
  int         t = 0;
  logic [3:0] e_an = 4'hF;
  logic [7:0] e_seg = 8'hFF;
  logic       e_fs = 1'b0;

  function automatic int slot(int n);
    return (n / R - 1) % 4;
  endfunction

  function automatic logic [7:0] expect_seg(int n, logic [3:0] v,
                                            logic [3:0] m);
    int d = slot(n);
    logic on = (((n - 1) / B) % 2) == 0;
    logic [7:0] s = (!on && m[3-d]) ? 8'hFF : tab[v];
`ifdef SCAN_DP_EN
    if (d == 1) s[7] = 1'b0;
`endif
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      t     <= 0;
      e_an  <= 4'hF;
      e_seg <= 8'hFF;
      e_fs  <= 1'b0;
    end else begin
      t    <= t + 1;
      e_fs <= 1'b0;
      if ((t + 1) % R == 0) begin
        if (slot(t + 1) == 0) begin
          fr[0] <= min10;
          fr[1] <= min1;
          fr[2] <= sec10;
          fr[3] <= sec1;
        end
        e_an  <= 4'(~(4'b1000 >> slot(t + 1)));
        e_seg <= expect_seg(t + 1,
                            slot(t + 1) == 0 ? min10 : fr[slot(t + 1)],
                            blink_mask);
        e_fs  <= (slot(t + 1) == 0);
      end
    end
  end

  task automatic test_reset();
    int fs_cnt = 0;
    rst = 1'b0;
    {min10, min1, sec10, sec1} = {4'd1, 4'd2, 4'd3, 4'd4};
    blink_mask = 4'b0000;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (an !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: an=%b seg=%h fs=%b, want 1111 ff 0",
                 an, seg, frame_start);
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      fs_cnt += int'(frame_start);
      vectors++;
      if ({an, seg, frame_start} !== {e_an, e_seg, e_fs}) begin
        errors++;
        $display("FAIL startup_model c%0d: an=%b seg=%h fs=%b, want %b %h %b",
                 i, an, seg, frame_start, e_an, e_seg, e_fs);
      end
      if (i == 4) begin
        vectors++;
        if (an !== 4'b0111 || seg !== 8'hF9 || frame_start !== 1'b1) begin
          errors++;
          $display("FAIL startup_first: an=%b seg=%h fs=%b, want 0111 f9 1",
                   an, seg, frame_start);
        end
      end
    end
    vectors++;
    if (fs_cnt !== 1) begin
      errors++;
      $display("FAIL startup_pulses: got %0d, want 1", fs_cnt);
    end
  endtask

  task automatic test_scan();
    logic [3:0] prev = an;
    int run = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, frame_start} !== {e_an, e_seg, e_fs}) begin
        errors++;
        $display("FAIL scan: an=%b seg=%h fs=%b, want %b %h %b",
                 an, seg, frame_start, e_an, e_seg, e_fs);
      end
      run = (an == prev) ? run + 1 : 1;
      if (an != prev && i > 4) begin
        vectors++;
        if (an !== 4'({prev[0], prev[3:1]})) begin
          errors++;
          $display("FAIL scan_order: an=%b after %b", an, prev);
        end
      end
      prev = an;
    end
  endtask

  task automatic test_snapshot();
    int k = 0;
    while (!frame_start && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    vectors++;
    if (!frame_start) begin
      errors++;
      $display("FAIL snap_wait: fs=%b, want 1", frame_start);
    end
    repeat (R) begin @(posedge clk); #1; end
    sec1 = 4'd7;
    for (int i = 1; i <= 26; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, frame_start} !== {e_an, e_seg, e_fs}) begin
        errors++;
        $display("FAIL snap_model: an=%b seg=%h fs=%b, want %b %h %b",
                 an, seg, frame_start, e_an, e_seg, e_fs);
      end
      if (i == 8 || i == 24) begin
        vectors++;
        if (an !== 4'b1110 || seg !== (i == 8 ? 8'h99 : 8'hF8)) begin
          errors++;
          $display("FAIL snap_sec1 c%0d: an=%b seg=%h, want 1110 %h",
                   i, an, seg, i == 8 ? 8'h99 : 8'hF8);
        end
      end
    end
  endtask

  task automatic test_blink();
    int blanks = 0;
    blink_mask = 4'b1100;
    for (int i = 0; i < 160; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, frame_start} !== {e_an, e_seg, e_fs}) begin
        errors++;
        $display("FAIL blink: an=%b seg=%h fs=%b, want %b %h %b",
                 an, seg, frame_start, e_an, e_seg, e_fs);
      end
      if (an == 4'b0111 && seg == 8'hFF) blanks++;
      if (an == 4'b1110) begin
        vectors++;
        if (seg !== 8'hF8) begin
          errors++;
          $display("FAIL blink_sec1: seg=%h, want f8", seg);
        end
      end
    end
    vectors++;
    if (blanks == 0) begin
      errors++;
      $display("FAIL blink_seen: blank cycles=%0d, want >0", blanks);
    end
    blink_mask = 4'b0000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, frame_start} !== {e_an, e_seg, e_fs}) begin
        errors++;
        $display("FAIL random: an=%b seg=%h fs=%b, want %b %h %b",
                 an, seg, frame_start, e_an, e_seg, e_fs);
      end
      if ($urandom_range(7) == 0) begin
        min10 = 4'($urandom_range(15));
        min1  = 4'($urandom_range(15));
        sec10 = 4'($urandom_range(15));
        sec1  = 4'($urandom_range(15));
        blink_mask = 4'($urandom_range(15));
      end
    end
    blink_mask = 4'b0000;
  endtask

  task automatic test_invalid_reset();
    int k = 0;
    logic [7:0] want_b;
`ifdef SCAN_DP_EN
    want_b = 8'h7F;
`else
    want_b = 8'hFF;
`endif
    {min10, min1, sec10, sec1} = {4'd1, 4'hB, 4'd3, 4'd4};
    @(posedge clk); #1;
    while (!frame_start && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    vectors++;
    if (!frame_start) begin
      errors++;
      $display("FAIL inv_wait: fs=%b, want 1", frame_start);
    end
    repeat (R) begin @(posedge clk); #1; end
    vectors++;
    if (an !== 4'b1011 || seg !== want_b) begin
      errors++;
      $display("FAIL invalid_digit: an=%b seg=%h, want 1011 %h",
               an, seg, want_b);
    end
    repeat (R) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (an !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL midreset: an=%b seg=%h fs=%b, want 1111 ff 0",
               an, seg, frame_start);
    end
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, frame_start} !== {e_an, e_seg, e_fs}) begin
        errors++;
        $display("FAIL restart_model: an=%b seg=%h fs=%b, want %b %h %b",
                 an, seg, frame_start, e_an, e_seg, e_fs);
      end
      if (i == 3 || i == 4) begin
        vectors++;
        if (an !== (i == 3 ? 4'hF : 4'b0111) ||
            seg !== (i == 3 ? 8'hFF : 8'hF9)) begin
          errors++;
          $display("FAIL restart c%0d: an=%b seg=%h", i, an, seg);
        end
      end
    end
  endtask

  initial begin
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    test_reset();
    test_scan();
    test_snapshot();
    test_blink();
    test_random();
    test_invalid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
